// File: rtl/microseq_control.sv
// Writable-control-store microsequencer: OP/BR/CALL/RET microwords, hardware
// return stack, sticky stack fault and a synchronous program-load mode.
module microseq_control #(
    parameter  int CS_SIZE     = 32,
    parameter  int RF_AW       = 3,
    parameter  int STACK_DEPTH = 4,
    localparam int CS_BITS     = $clog2(CS_SIZE),
    localparam int W           = 3*RF_AW + 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               prog_mode,
    input  logic               prog_we,
    input  logic [CS_BITS-1:0] prog_addr,
    input  logic [W-1:0]       prog_wdata,
    output logic [RF_AW-1:0]   fld_A,
    output logic [RF_AW-1:0]   fld_B,
    output logic [RF_AW-1:0]   fld_C,
    output logic               ldRF,
    output logic               selR_in,
    output logic               ldR_in,
    output logic               ldR_out,
    output logic [2:0]         alu_op,
    input  logic               cy,
    input  logic               neg,
    input  logic               zero,
    input  logic               ovf,
    input  logic               start,
    output logic               done,
    output logic               fault,
    output logic [CS_BITS-1:0] upc
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int F_CTL = W - 3 - 3*RF_AW;

    typedef enum logic [1:0] {
        UW_OP   = 2'b00,
        UW_BR   = 2'b01,
        UW_CALL = 2'b10,
        UW_RET  = 2'b11
    } uword_t;

    logic [W-1:0]       r_cs [CS_SIZE];
    logic [CS_BITS-1:0] r_stack [STACK_DEPTH];
    logic [CS_BITS-1:0] r_upc;
    logic [SP_W-1:0]    r_sp;
    logic               r_done;
    logic               r_fault;

    logic [W-1:0]       w_word;
    uword_t             w_type;
    logic [CS_BITS-1:0] w_upc_inc;
    logic [CS_BITS-1:0] w_target;
    logic [CS_BITS-1:0] w_ret_addr;
    logic [IDX_W-1:0]   w_push_idx;
    logic [IDX_W-1:0]   w_pop_idx;
    logic               w_cond;
    logic               w_nop;
    logic               w_push;
    logic [CS_BITS-1:0] w_upc_nxt;
    logic [SP_W-1:0]    w_sp_nxt;
    logic               w_done_nxt;
    logic               w_fault_nxt;

    assign w_word     = r_cs[r_upc];
    assign w_type     = uword_t'(w_word[W-1:W-2]);
    assign w_upc_inc  = r_upc + CS_BITS'(1);
    assign w_target   = w_word[CS_BITS-1:0];
    assign w_push_idx = r_sp[IDX_W-1:0];
    assign w_pop_idx  = IDX_W'(r_sp - SP_W'(1));
    assign w_ret_addr = r_stack[w_pop_idx];

    always_comb begin
        w_cond = 1'b0;
        case (w_word[W-3:W-5])
            3'd0:    w_cond = start;
            3'd1:    w_cond = zero;
            3'd2:    w_cond = neg;
            3'd3:    w_cond = cy;
            3'd4:    w_cond = ovf;
            3'd5:    w_cond = 1'b1;
            3'd6:    w_cond = r_done;
            default: w_cond = 1'b0;
        endcase
    end

    always_comb begin
        w_upc_nxt   = r_upc;
        w_sp_nxt    = r_sp;
        w_done_nxt  = r_done;
        w_fault_nxt = r_fault;
        w_push      = 1'b0;
        if (prog_mode) begin
            w_upc_nxt   = '0;
            w_sp_nxt    = '0;
            w_done_nxt  = 1'b0;
            w_fault_nxt = 1'b0;
        end else if (!r_fault) begin
            case (w_type)
                UW_OP: begin
                    w_upc_nxt = w_upc_inc;
                    if (w_word[F_CTL-7])
                        w_done_nxt = 1'b1;
                    else if (w_word[F_CTL-8])
                        w_done_nxt = 1'b0;
                end
                UW_BR: begin
                    w_upc_nxt = (w_cond == w_word[W-6]) ? w_target : w_upc_inc;
                end
                UW_CALL: begin
                    // A faulting CALL/RET leaves upc on the offending word.
                    if (r_sp == SP_W'(STACK_DEPTH)) begin
                        w_fault_nxt = 1'b1;
                    end else begin
                        w_push    = 1'b1;
                        w_sp_nxt  = r_sp + SP_W'(1);
                        w_upc_nxt = w_target;
                    end
                end
                default: begin
                    if (r_sp == '0) begin
                        w_fault_nxt = 1'b1;
                    end else begin
                        w_sp_nxt  = r_sp - SP_W'(1);
                        w_upc_nxt = w_ret_addr;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_upc   <= '0;
            r_sp    <= '0;
            r_done  <= 1'b0;
            r_fault <= 1'b0;
            for (int unsigned i = 0; i < STACK_DEPTH; i++)
                r_stack[i] <= '0;
        end else begin
            r_upc   <= w_upc_nxt;
            r_sp    <= w_sp_nxt;
            r_done  <= w_done_nxt;
            r_fault <= w_fault_nxt;
            if (w_push)
                r_stack[w_push_idx] <= w_upc_inc;
        end
    end

    // Store is deliberately outside the reset domain so programs survive rst_n.
    always_ff @(posedge clk) begin
        if (prog_mode && prog_we)
            r_cs[prog_addr] <= prog_wdata;
    end

    assign w_nop   = !rst_n || prog_mode || r_fault || (w_type != UW_OP);
    assign fld_A   = w_nop ? '0 : w_word[W-3 -: RF_AW];
    assign fld_B   = w_nop ? '0 : w_word[W-3-RF_AW -: RF_AW];
    assign fld_C   = w_nop ? '0 : w_word[W-3-2*RF_AW -: RF_AW];
    assign ldRF    = !w_nop && w_word[F_CTL];
    assign ldR_in  = !w_nop && w_word[F_CTL-1];
    assign ldR_out = !w_nop && w_word[F_CTL-2];
    assign selR_in = !w_nop && w_word[F_CTL-3];
    assign alu_op  = w_nop ? '0 : w_word[F_CTL-4 -: 3];

    assign done  = r_done;
    assign fault = r_fault;
    assign upc   = r_upc;

endmodule

// File: tb/tb_microseq_control.sv
// Randomized and directed bench for microseq_control against a queue-based
// behavioural model of the microsequencer.
module tb_microseq_control;

    localparam int CS_SIZE     = 32;
    localparam int RF_AW       = 3;
    localparam int STACK_DEPTH = 4;
    localparam int CS_BITS     = $clog2(CS_SIZE);
    localparam int W           = 3*RF_AW + 12;
    localparam int DP_W        = 3*RF_AW + 7;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               prog_mode, prog_we;
    logic [CS_BITS-1:0] prog_addr;
    logic [W-1:0]       prog_wdata;
    logic [RF_AW-1:0]   fld_A, fld_B, fld_C;
    logic               ldRF, selR_in, ldR_in, ldR_out;
    logic [2:0]         alu_op;
    logic               cy, neg, zero, ovf, start;
    logic               done, fault;
    logic [CS_BITS-1:0] upc;
    logic [DP_W-1:0]    dp_bus;

    microseq_control #(
        .CS_SIZE(CS_SIZE),
        .RF_AW(RF_AW),
        .STACK_DEPTH(STACK_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .prog_mode(prog_mode), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .fld_A(fld_A), .fld_B(fld_B), .fld_C(fld_C),
        .ldRF(ldRF), .selR_in(selR_in), .ldR_in(ldR_in), .ldR_out(ldR_out),
        .alu_op(alu_op),
        .cy(cy), .neg(neg), .zero(zero), .ovf(ovf),
        .start(start), .done(done), .fault(fault), .upc(upc)
    );

    always #5 clk = ~clk;

    // word layout below the type: A, B, C, ldRF, ldR_in, ldR_out, selR_in, alu, set, clr, spare
    assign dp_bus = {fld_A, fld_B, fld_C, ldRF, ldR_in, ldR_out, selR_in, alu_op};

    logic [W-1:0] m_cs [CS_SIZE];
    int           m_upc;
    int           m_stack [$];
    logic         m_done, m_fault;
    int           n_checks = 0;
    int           n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    function automatic int kind(input logic [W-1:0] w);
        return int'(w >> (W-2));
    endfunction

    task automatic model_reset();
        m_upc = 0;
        m_stack.delete();
        m_done = 1'b0;
        m_fault = 1'b0;
    endtask

    task automatic model_edge();
        logic [W-1:0] w;
        logic         c [8];
        int           sel;
        if (prog_mode) begin
            if (prog_we) m_cs[prog_addr] = prog_wdata;
            model_reset();
        end else if (!m_fault) begin
            w = m_cs[m_upc];
            case (kind(w))
                0: begin
                    m_upc = (m_upc + 1) % CS_SIZE;
                    if (w[2]) m_done = 1'b1;
                    else if (w[1]) m_done = 1'b0;
                end
                1: begin
                    c = '{start, zero, neg, cy, ovf, 1'b1, m_done, 1'b0};
                    sel = int'(w >> (W-5)) % 8;
                    m_upc = (c[sel] == w[W-6]) ? int'(w) % CS_SIZE : (m_upc + 1) % CS_SIZE;
                end
                2: begin
                    if (m_stack.size() == STACK_DEPTH) m_fault = 1'b1;
                    else begin
                        m_stack.push_back((m_upc + 1) % CS_SIZE);
                        m_upc = int'(w) % CS_SIZE;
                    end
                end
                default: begin
                    if (m_stack.size() == 0) m_fault = 1'b1;
                    else m_upc = m_stack.pop_back();
                end
            endcase
        end
    endtask

    task automatic compare_all();
        int exp_dp;
        exp_dp = 0;
        if (!prog_mode && !m_fault && kind(m_cs[m_upc]) == 0)
            exp_dp = int'(m_cs[m_upc] >> 3) % (1 << DP_W);
        check("upc", 32'(upc), m_upc);
        check("done", 32'(done), 32'(m_done));
        check("fault", 32'(fault), 32'(m_fault));
        check("dp", 32'(dp_bus), exp_dp);
    endtask

    task automatic step();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic write_word(input int a, input logic [W-1:0] d);
        prog_mode = 1'b1;
        prog_we = 1'b1;
        prog_addr = CS_BITS'(a);
        prog_wdata = d;
        step();
        prog_we = 1'b0;
    endtask

    task automatic release_prog();
        prog_mode = 1'b0;
        prog_we = 1'b0;
        {start, zero, neg, cy, ovf} = '0;
    endtask

    function automatic logic [W-1:0] mk_op(input logic ds, input logic dc);
        logic [W-1:0] w;
        w = W'($urandom);
        w[W-1:W-2] = 2'b00;
        w[2] = ds;
        w[1] = dc;
        return w;
    endfunction

    function automatic logic [W-1:0] mk_br(input int cnd, input logic pol, input int tgt);
        logic [W-1:0] w;
        w = '0;
        w[W-1:W-2] = 2'b01;
        w[W-3:W-5] = 3'(cnd);
        w[W-6] = pol;
        w[CS_BITS-1:0] = CS_BITS'(tgt);
        return w;
    endfunction

    function automatic logic [W-1:0] mk_call(input int tgt);
        logic [W-1:0] w;
        w = '0;
        w[W-1:W-2] = 2'b10;
        w[CS_BITS-1:0] = CS_BITS'(tgt);
        return w;
    endfunction

    function automatic logic [W-1:0] mk_ret();
        logic [W-1:0] w;
        w = W'($urandom);
        w[W-1:W-2] = 2'b11;
        return w;
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        int r;
        r = $urandom_range(0, 99);
        w = W'($urandom);
        w[W-1:W-2] = (r < 50) ? 2'b00 : (r < 75) ? 2'b01 : (r < 87) ? 2'b10 : 2'b11;
        return w;
    endfunction

    initial begin
        rst_n = 1'b0;
        prog_mode = 1'b1;
        prog_we = 1'b0;
        prog_addr = '0;
        prog_wdata = '0;
        {start, zero, neg, cy, ovf} = '0;
        model_reset();
        #3;
        check("rst_upc", 32'(upc), 0);
        check("rst_done", 32'(done), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_dp", 32'(dp_bus), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // load + done_set, then async reset mid-run
        for (int a = 0; a < 8; a++) write_word(a, mk_op(a == 2, 1'b0));
        release_prog();
        for (int i = 0; i < 5; i++) step();
        check("run_upc5", 32'(upc), 5);
        check("run_done", 32'(done), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_upc", 32'(upc), 0);
        check("arst_done", 32'(done), 0);
        check("arst_fault", 32'(fault), 0);
        check("arst_dp", 32'(dp_bus), 0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step();

        // branch polarity on start, constant-0 condition
        write_word(0, mk_br(0, 1'b0, 0));
        write_word(1, mk_br(7, 1'b0, 0));
        release_prog();
        for (int i = 0; i < 5; i++) step();
        check("br_hold", 32'(upc), 0);
        start = 1'b1;
        step();
        check("br_start", 32'(upc), 1);
        start = 1'b0;
        step();
        check("br_c7", 32'(upc), 0);

        // nested calls/returns, then overflow on the fifth nested call
        write_word(0, mk_call(10));  write_word(10, mk_call(20));
        write_word(20, mk_call(25)); write_word(25, mk_call(30));
        write_word(30, mk_ret());    write_word(26, mk_ret());
        write_word(21, mk_ret());    write_word(11, mk_ret());
        write_word(1, mk_call(3));   write_word(3, mk_call(6));
        write_word(6, mk_call(9));   write_word(9, mk_call(12));
        write_word(12, mk_call(15));
        release_prog();
        for (int i = 0; i < 8; i++) step();
        check("ret_chain", 32'(upc), 1);
        for (int i = 0; i < 5; i++) step();
        check("ovf_fault", 32'(fault), 1);
        check("ovf_upc", 32'(upc), 12);
        for (int i = 0; i < 3; i++) step();
        check("ovf_frozen", 32'(upc), 12);
        check("ovf_dp", 32'(dp_bus), 0);

        // underflow, cleared by a prog_mode pulse
        write_word(0, mk_ret());
        release_prog();
        step();
        check("unf_fault", 32'(fault), 1);
        check("unf_upc", 32'(upc), 0);
        prog_mode = 1'b1;
        step();
        check("unf_clear", 32'(fault), 0);
        release_prog();

        // wrap: OP at last word, then CALL at last word pushes 0
        write_word(0, mk_br(5, 1'b1, CS_SIZE-1));
        write_word(CS_SIZE-1, mk_op(1'b0, 1'b0));
        release_prog();
        step(); step();
        check("wrap_op", 32'(upc), 0);
        write_word(CS_SIZE-1, mk_call(5));
        write_word(5, mk_ret());
        release_prog();
        step(); step(); step();
        check("wrap_call", 32'(upc), 0);
        check("wrap_fault", 32'(fault), 0);

        // random programs, random flags, stray writes and prog_mode pulses
        for (int round = 0; round < 6; round++) begin
            for (int a = 0; a < CS_SIZE; a++) write_word(a, rand_word());
            release_prog();
            for (int i = 0; i < 80; i++) begin
                {start, zero, neg, cy, ovf} = 5'($urandom);
                prog_we = ($urandom_range(0, 3) == 0);
                prog_addr = CS_BITS'($urandom);
                prog_wdata = W'($urandom);
                prog_mode = ($urandom_range(0, 39) == 0);
                step();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
